// File: rtl/i2c_slave_if.sv
// I2C pin bundle: open-drain SDA as an _i/_o/_t triplet, SCL observed only.
interface i2c_slave_if;
  logic SCL_i;
  logic SDA_i;
  logic SDA_o;
  logic SDA_t;

  modport slave  (input SCL_i, SDA_i, output SDA_o, SDA_t);
  modport master (output SCL_i, SDA_i, input SDA_o, SDA_t);
endinterface

// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; hands write bytes to local logic
// and requests read bytes from it. No clock stretching.
module i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  output logic       busy,
  output logic       read_nwrite,
  output logic [7:0] data_o,
  output logic       data_available,
  output logic       data_request,
  input  logic [7:0] data_i,
  input  logic       data_valid,
  output logic       tx_underrun,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl, sda;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] cnt;
  logic       done;
  logic [7:0] rx_sr, tx_sr, tx_n, hold, tx_load_val;
  logic       have, have_eff, capture, ack_bit;
  logic       sda_t, sda_t_n;
  logic       load_tx, rx_byte, hit, set_req, nack;

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  assign bus.SDA_o = 1'b0;
  assign bus.SDA_t = sda_t;

  // A byte supplied in the very cycle it is consumed still counts.
  assign capture     = data_request & data_valid;
  assign have_eff    = have | capture;
  assign tx_load_val = have ? hold : (capture ? data_i : 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    load_tx = 1'b0;
    rx_byte = 1'b0;
    hit     = 1'b0;
    set_req = 1'b0;
    nack    = 1'b0;
    if (stop_det) state_n = IDLE;
    else if (start_det) state_n = ADDR;
    else begin
      case (state)
        ADDR: if (scl_fall && done) begin
          if (rx_sr[7:1] == addr) begin
            state_n = ADDR_ACK;
            hit     = 1'b1;
            set_req = rx_sr[0];
          end else begin
            state_n = WAIT_STOP;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (read_nwrite) begin
            state_n = TX;
            load_tx = 1'b1;
          end else begin
            state_n = RX;
          end
        end
        RX: if (scl_fall && done) begin
          state_n = RX_ACK;
          rx_byte = 1'b1;
        end
        RX_ACK: if (scl_fall) state_n = RX;
        TX: if (scl_fall && cnt == 3'd7) begin
          state_n = TX_ACK;
          set_req = 1'b1;
        end
        TX_ACK: if (scl_fall) begin
          if (!ack_bit) begin
            state_n = TX;
            load_tx = 1'b1;
          end else begin
            state_n = WAIT_STOP;
            nack    = 1'b1;
          end
        end
        default: state_n = state;
      endcase
    end

    tx_n = tx_sr;
    if (load_tx) tx_n = tx_load_val;
    else if (state == TX && scl_fall) tx_n = {tx_sr[6:0], 1'b1};

    case (state_n)
      ADDR_ACK, RX_ACK: sda_t_n = 1'b0;
      TX:               sda_t_n = tx_n[7];
      default:          sda_t_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync       <= '1;
      sda_sync       <= '1;
      scl_d          <= 1'b1;
      sda_d          <= 1'b1;
      cnt            <= 3'd0;
      done           <= 1'b0;
      rx_sr          <= 8'h00;
      tx_sr          <= 8'h00;
      hold           <= 8'h00;
      have           <= 1'b0;
      ack_bit        <= 1'b1;
      sda_t          <= 1'b1;
      busy           <= 1'b0;
      read_nwrite    <= 1'b0;
      data_o         <= 8'h00;
      data_available <= 1'b0;
      data_request   <= 1'b0;
      tx_underrun    <= 1'b0;
    end else begin
      scl_sync       <= {scl_sync[SYNC_STAGES-2:0], bus.SCL_i};
      sda_sync       <= {sda_sync[SYNC_STAGES-2:0], bus.SDA_i};
      scl_d          <= scl;
      sda_d          <= sda;
      sda_t          <= sda_t_n;
      tx_sr          <= tx_n;
      data_available <= rx_byte;
      tx_underrun    <= load_tx & ~have_eff;

      // Receive bits count on SCL rise, transmit bits on SCL fall.
      if (start_det || stop_det) begin
        cnt  <= 3'd0;
        done <= 1'b0;
      end else if (scl_rise && (state == ADDR || state == RX)) begin
        rx_sr <= {rx_sr[6:0], sda};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) done <= 1'b1;
      end else if (scl_fall) begin
        done <= 1'b0;
        if (state == TX) cnt <= cnt + 3'd1;
      end

      if (state == TX_ACK && scl_rise) ack_bit <= sda;
      if (rx_byte) data_o <= rx_sr;
      if (hit) read_nwrite <= rx_sr[0];

      if (start_det || stop_det || nack) busy <= 1'b0;
      else if (hit)                      busy <= 1'b1;

      if (start_det || stop_det || load_tx || nack) data_request <= 1'b0;
      else if (set_req)                             data_request <= 1'b1;
      else if (capture)                             data_request <= 1'b0;

      if (start_det || stop_det || load_tx) have <= 1'b0;
      else if (capture) begin
        have <= 1'b1;
        hold <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master, byte scoreboards for RX data and
// for bytes the local side supplies, immediate-assertion checks.
module tb_i2c_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] addr = 7'h48;
  logic       busy, read_nwrite, data_available, data_request, tx_underrun;
  logic [7:0] data_o;
  logic [7:0] data_i = 8'h00;
  logic       data_valid = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_if bus();
  assign bus.SCL_i = scl_m;
  assign bus.SDA_i = sda_m & (bus.SDA_t | bus.SDA_o);

  i2c_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .busy(busy), .read_nwrite(read_nwrite),
    .data_o(data_o), .data_available(data_available), .data_request(data_request),
    .data_i(data_i), .data_valid(data_valid), .tx_underrun(tx_underrun), .bus(bus)
  );

  int checks = 0, passed = 0;
  int avail_cnt = 0, unr_cnt = 0, drive_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] sup_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin passed++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor: pops the RX scoreboard on every data_available cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.SDA_t === 1'b0) drive_cnt++;
      if (tx_underrun === 1'b1) unr_cnt++;
      if (data_available === 1'b1) begin
        avail_cnt++;
        if (rx_q.size() > 0) check("rx_byte", data_o, rx_q.pop_front());
      end
    end
  end

  // Local side: supplies the next queued byte for one cycle when requested.
  initial begin
    forever begin
      @(negedge clk);
      data_valid = 1'b0;
      if (data_request === 1'b1 && sup_q.size() > 0) begin
        data_i     = sup_q.pop_front();
        data_valid = 1'b1;
      end
    end
  end

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b; q();
    scl_m = 1'b1; q();
    r = bus.SDA_i; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  initial begin
    logic       a, r;
    logic [7:0] d;
    int         avail0;

    repeat (3) @(negedge clk);
    check("rst_sda_t", bus.SDA_t, 1'b1);
    check("rst_sda_o", bus.SDA_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rnw", read_nwrite, 1'b0);
    check("rst_data_o", data_o, 8'h00);
    check("rst_avail", data_available, 1'b0);
    check("rst_req", data_request, 1'b0);
    check("rst_unr", tx_underrun, 1'b0);
    rst = 1'b1;
    q();

    // write two data bytes
    i2c_start();
    write_byte(8'h90, a);  check("w_addr_ack", a, 1'b0);
    check("w_busy_on", busy, 1'b1);
    check("w_rnw", read_nwrite, 1'b0);
    rx_q.push_back(8'hA5);
    write_byte(8'hA5, a);  check("w_d0_ack", a, 1'b0);
    rx_q.push_back(8'h3C);
    write_byte(8'h3C, a);  check("w_d1_ack", a, 1'b0);
    check("w_busy_pre_stop", busy, 1'b1);
    i2c_stop(); q();
    check("w_busy_off", busy, 1'b0);
    check("w_avail_cnt", avail_cnt, 2);
    check("w_rx_q_empty", rx_q.size(), 0);

    // address mismatch
    drive_cnt = 0;
    i2c_start();
    write_byte(8'h4A, a);  check("mm_addr_nack", a, 1'b1);
    check("mm_busy", busy, 1'b0);
    write_byte(8'h55, a);  check("mm_data_nack", a, 1'b1);
    i2c_stop(); q();
    check("mm_never_driven", drive_cnt, 0);
    check("mm_avail_cnt", avail_cnt, 2);

    // read two bytes, ACK then NACK
    sup_q.push_back(8'h5A);
    sup_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'h91, a);  check("r_addr_ack", a, 1'b0);
    check("r_rnw", read_nwrite, 1'b1);
    read_byte(1'b0, d);    check("r_byte0", d, 8'h5A);
    read_byte(1'b1, d);    check("r_byte1", d, 8'hC3);
    q();
    check("r_busy_after_nack", busy, 1'b0);
    check("r_req_after_nack", data_request, 1'b0);
    i2c_stop(); q();
    check("r_no_underrun", unr_cnt, 0);
    check("r_sup_q_empty", sup_q.size(), 0);

    // underrun: nothing supplied
    i2c_start();
    write_byte(8'h91, a);  check("u_addr_ack", a, 1'b0);
    read_byte(1'b1, d);    check("u_byte", d, 8'hFF);
    i2c_stop(); q();
    check("u_pulse_cnt", unr_cnt, 1);

    // repeated START: write then read
    avail0 = avail_cnt;
    i2c_start();
    write_byte(8'h90, a);  check("rs_waddr_ack", a, 1'b0);
    check("rs_rnw0", read_nwrite, 1'b0);
    rx_q.push_back(8'h01);
    write_byte(8'h01, a);  check("rs_wdata_ack", a, 1'b0);
    sup_q.push_back(8'h77);
    i2c_start();
    write_byte(8'h91, a);  check("rs_raddr_ack", a, 1'b0);
    check("rs_rnw1", read_nwrite, 1'b1);
    read_byte(1'b1, d);    check("rs_rbyte", d, 8'h77);
    i2c_stop(); q();
    check("rs_data_o", data_o, 8'h01);
    check("rs_avail_cnt", avail_cnt - avail0, 1);
    check("rs_rx_q_empty", rx_q.size(), 0);

    // reset during the 4th data bit of a write
    i2c_start();
    write_byte(8'h90, a);  check("rm_addr_ack", a, 1'b0);
    check("rm_busy_on", busy, 1'b1);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    rst = 1'b0;
    @(posedge clk); #1;
    check("rm_sda_t", bus.SDA_t, 1'b1);
    check("rm_busy", busy, 1'b0);
    check("rm_rnw", read_nwrite, 1'b0);
    check("rm_data_o", data_o, 8'h00);
    check("rm_req", data_request, 1'b0);
    check("rm_avail", data_available, 1'b0);
    check("rm_unr", tx_underrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q();
    scl_m = 1'b0; q();
    scl_m = 1'b1; q();
    i2c_start();
    write_byte(8'h90, a);  check("rm2_addr_ack", a, 1'b0);
    rx_q.push_back(8'h42);
    write_byte(8'h42, a);  check("rm2_data_ack", a, 1'b0);
    i2c_stop(); q();
    check("rm2_busy_off", busy, 1'b0);
    check("rm2_rx_q_empty", rx_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
